dot_product_accumulator: RTL and testbench
==========================================

Name: dot_product_accumulator

Overview:
Downstream consumer of the parametric combinational multiplier. It accepts a stream of 2*WIDTH-bit products over a valid/ready handshake and sums a programmed number of them into a wide accumulator. It then presents the dot-product result over a second valid/ready handshake. Sits between the multiplier array output and the result writeback/register stage.

Parameters:
WIDTH, 8, multiplier operand width; product input is 2*WIDTH bits
ACC_WIDTH, 2*WIDTH+8, accumulator/result width; must be >= 2*WIDTH
LEN_WIDTH, 8, width of the product-count field (max 2^LEN_WIDTH-1 products per run)

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
start  input  1  begin a run; sampled only in IDLE
len  input  LEN_WIDTH  number of products to sum; latched on accepted start
clear  input  1  synchronous abort; returns block to IDLE from any state
p_valid  input  1  product beat valid
p_ready  output  1  block accepts product beat
p_data  input  2*WIDTH  unsigned product from multiplier
res_valid  output  1  result available
res_ready  input  1  downstream accepts result
res_data  output  ACC_WIDTH  accumulated sum
res_ovf  output  1  sticky overflow flag for the current run
busy  output  1  high in ACCUM or DONE

Behaviour:
- Reset (rst_n low, async): state IDLE; acc, count, res_data = 0; res_ovf, res_valid, p_ready, busy = 0.
- States: IDLE, ACCUM, DONE; one-hot or binary, implementer's choice.
- IDLE: p_ready=0, res_valid=0. When start=1 and clear=0: latch len, acc<=0, count<=0, res_ovf<=0.
  - Next state is ACCUM if len!=0.
  - Next state is DONE if len==0; the result is 0 and res_valid rises on the following cycle.
- ACCUM: p_ready=1, decoded from the state register only, with no combinational path from p_valid.
  - Beat transfer = p_valid & p_ready.
  - On a transfer: acc <= acc + zero-extend(p_data), count <= count+1.
  - On the transfer with count==len-1: go to DONE.
  - Throughput is one product per cycle. Idle cycles (p_valid=0) leave acc and count unchanged.
- DONE: res_valid=1, p_ready=0. res_data holds the final acc and must stay stable while res_valid=1 and res_ready=0.
  - On res_valid & res_ready: go to IDLE and drop res_valid next cycle.
- Latency: res_valid asserts the cycle after the last accepted beat.
- start while not in IDLE: ignored, no effect.
- clear:
  - Has priority over every other event, including start in IDLE and a beat transfer or result handshake in the same cycle.
  - Forces IDLE with res_valid=0 and p_ready=0.
  - acc, res_data and res_ovf are zeroed.
- Arithmetic: unsigned.
  - If the (ACC_WIDTH+1)-bit sum has its carry bit set, res_ovf <= 1 (sticky until the next start, clear or reset).
  - Without the optional feature, acc wraps modulo 2^ACC_WIDTH.
- Reset mid-run: the async reset aborts immediately, with no partial result emitted.

Optional Feature:
Macro DOT_ACC_SATURATE_EN.
- Defined: on overflow, acc clamps to all-ones (2^ACC_WIDTH-1) and stays there for the rest of the run. res_ovf is still set.
- Undefined: wrap-around as described above. res_ovf behaviour is identical in both builds.

Test Plan:
1. Defaults, start with len=3; beats 6, 15, 65025 back-to-back -> res_valid one cycle after third beat; res_data=65046, res_ovf=0.
2. start with len=0 -> no p_ready; res_valid next cycle with res_data=0; res_ready=1 -> IDLE, busy=0.
3. len=4, beats 1,2,3,4 with p_valid gapped every other cycle; res_ready held low 5 cycles -> res_data=10 stable throughout; start pulses during the run ignored.
4. ACC_WIDTH=17, len=3, beats 65025 x3 -> res_ovf=1; res_data=64003 without the macro, 131071 with DOT_ACC_SATURATE_EN.
5. len=5, rst_n low after 2 beats -> all outputs 0 immediately. After release, len=1, beat 9 -> res_data=9, res_ovf=0.
6. clear asserted in the same cycle as start, and again in the same cycle as a res_valid & res_ready handshake -> IDLE, res_valid=0, res_data=0, no run started.

Source files
------------

// File: rtl/dot_product_accumulator.sv
// Sums a programmed number of unsigned products and presents the total over a valid/ready result port.
// Latency: res_valid rises one cycle after the last accepted beat (one cycle after start when len==0).
// Backpressure: p_ready is high only in ACCUM; res_data holds while res_ready is low. Optional macro: DOT_ACC_SATURATE_EN.
module dot_product_accumulator #(
    parameter int WIDTH     = 8,
    parameter int ACC_WIDTH = 2*WIDTH+8,
    parameter int LEN_WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [LEN_WIDTH-1:0] len,
    input  logic                 clear,
    input  logic                 p_valid,
    output logic                 p_ready,
    input  logic [2*WIDTH-1:0]   p_data,
    output logic                 res_valid,
    input  logic                 res_ready,
    output logic [ACC_WIDTH-1:0] res_data,
    output logic                 res_ovf,
    output logic                 busy
);

    typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;

    state_t                 state, state_nxt;
    logic [ACC_WIDTH-1:0]   acc;
    logic [ACC_WIDTH-1:0]   acc_add;
    logic [ACC_WIDTH:0]     sum;
    logic [LEN_WIDTH-1:0]   count;
    logic [LEN_WIDTH-1:0]   len_q;
    logic                   ovf;
    logic                   xfer;
    logic                   last;

    // Handshake outputs decode straight from the state register.
    assign p_ready   = (state == ACCUM);
    assign res_valid = (state == DONE);
    assign busy      = (state != IDLE);
    assign res_data  = acc;
    assign res_ovf   = ovf;

    assign xfer = p_valid & p_ready;
    assign last = (count == len_q - LEN_WIDTH'(1));
    assign sum  = {1'b0, acc} + (ACC_WIDTH+1)'(p_data);

`ifdef DOT_ACC_SATURATE_EN
    assign acc_add = sum[ACC_WIDTH] ? {ACC_WIDTH{1'b1}} : sum[ACC_WIDTH-1:0];
`else
    assign acc_add = sum[ACC_WIDTH-1:0];
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        if (clear) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        state_nxt = (len == '0) ? DONE : ACCUM;
                    end
                end
                ACCUM: begin
                    if (xfer && last) begin
                        state_nxt = DONE;
                    end
                end
                DONE: begin
                    if (res_ready) begin
                        state_nxt = IDLE;
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc   <= '0;
            count <= '0;
            len_q <= '0;
            ovf   <= 1'b0;
        end else if (clear) begin
            acc   <= '0;
            count <= '0;
            ovf   <= 1'b0;
        end else if (state == IDLE) begin
            if (start) begin
                len_q <= len;
                acc   <= '0;
                count <= '0;
                ovf   <= 1'b0;
            end
        end else if (xfer) begin
            acc   <= acc_add;
            count <= count + LEN_WIDTH'(1);
            if (sum[ACC_WIDTH]) begin
                ovf <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_dot_product_accumulator.sv
// Directed bench: scoreboard queues fed by stimulus, drained by monitors on each result handshake.
module tb_dot_product_accumulator;

    typedef struct packed {
        logic [23:0] data;
        logic        ovf;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    always #5 clk = ~clk;

    // Default-parameter instance
    logic        start = 0, clear = 0, p_valid = 0, res_ready = 0;
    logic [7:0]  len = 0;
    logic [15:0] p_data = 0;
    logic        p_ready, res_valid, res_ovf, busy;
    logic [23:0] res_data;

    // Narrow-accumulator instance for overflow checks
    logic        start2 = 0, clear2 = 0, p_valid2 = 0, res_ready2 = 0;
    logic [7:0]  len2 = 0;
    logic [15:0] p_data2 = 0;
    logic        p_ready2, res_valid2, res_ovf2, busy2;
    logic [16:0] res_data2;

    int compared = 0;
    int mismatched = 0;
    exp_t q1[$];
    exp_t q2[$];

    dot_product_accumulator dut (
        .clk(clk), .rst_n(rst_n), .start(start), .len(len), .clear(clear),
        .p_valid(p_valid), .p_ready(p_ready), .p_data(p_data),
        .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
        .res_ovf(res_ovf), .busy(busy)
    );

    dot_product_accumulator #(.WIDTH(8), .ACC_WIDTH(17), .LEN_WIDTH(8)) dut2 (
        .clk(clk), .rst_n(rst_n), .start(start2), .len(len2), .clear(clear2),
        .p_valid(p_valid2), .p_ready(p_ready2), .p_data(p_data2),
        .res_valid(res_valid2), .res_ready(res_ready2), .res_data(res_data2),
        .res_ovf(res_ovf2), .busy(busy2)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Monitors: a handshake completes at the next rising edge unless clear overrides it.
    always @(negedge clk) begin
        if (rst_n && res_valid && res_ready && !clear) begin
            if (q1.size() == 0) begin
                compared++;
                mismatched++;
                $display("FAIL unexpected_result: got %0d expected none", res_data);
            end else begin
                exp_t e;
                e = q1.pop_front();
                chk("res_data", 32'(res_data), 32'(e.data));
                chk("res_ovf", 32'(res_ovf), 32'(e.ovf));
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n && res_valid2 && res_ready2 && !clear2) begin
            if (q2.size() == 0) begin
                compared++;
                mismatched++;
                $display("FAIL unexpected_result2: got %0d expected none", res_data2);
            end else begin
                exp_t e;
                e = q2.pop_front();
                chk("res_data2", 32'(res_data2), 32'(e.data));
                chk("res_ovf2", 32'(res_ovf2), 32'(e.ovf));
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        #12;
        chk("rst_p_ready", 32'(p_ready), 0);
        chk("rst_res_valid", 32'(res_valid), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_res_data", 32'(res_data), 0);
        chk("rst_res_ovf", 32'(res_ovf), 0);
        tick();
        rst_n = 1'b1;
        tick();

        // 1: three back-to-back beats
        q1.push_back('{data: 24'd65046, ovf: 1'b0});
        start = 1; len = 3;
        tick();
        start = 0;
        chk("t1_p_ready", 32'(p_ready), 1);
        p_valid = 1; p_data = 6;     tick();
        p_data = 15;                 tick();
        chk("t1_not_yet_valid", 32'(res_valid), 0);
        p_data = 65025;              tick();
        p_valid = 0;
        chk("t1_latency_valid", 32'(res_valid), 1);
        chk("t1_p_ready_done", 32'(p_ready), 0);
        res_ready = 1; tick(); res_ready = 0;
        chk("t1_idle_busy", 32'(busy), 0);

        // 2: zero-length run
        q1.push_back('{data: 24'd0, ovf: 1'b0});
        start = 1; len = 0;
        tick();
        start = 0;
        chk("t2_p_ready", 32'(p_ready), 0);
        chk("t2_res_valid", 32'(res_valid), 1);
        res_ready = 1; tick(); res_ready = 0;
        chk("t2_busy", 32'(busy), 0);
        chk("t2_res_valid_drop", 32'(res_valid), 0);

        // 3: gapped beats, stray start pulses, held result
        q1.push_back('{data: 24'd10, ovf: 1'b0});
        start = 1; len = 4;
        tick();
        for (int i = 0; i < 4; i++) begin
            start = 0; p_valid = 1; p_data = 16'(i + 1);
            tick();
            p_valid = 0; start = 1; len = 0;
            tick();
        end
        start = 0;
        for (int i = 0; i < 5; i++) begin
            chk("t3_hold_valid", 32'(res_valid), 1);
            chk("t3_hold_data", 32'(res_data), 10);
            tick();
        end
        res_ready = 1; tick(); res_ready = 0;
        chk("t3_busy", 32'(busy), 0);

        // 4: overflow on the 17-bit accumulator
`ifdef DOT_ACC_SATURATE_EN
        q2.push_back('{data: 24'd131071, ovf: 1'b1});
`else
        q2.push_back('{data: 24'd64003, ovf: 1'b1});
`endif
        start2 = 1; len2 = 3;
        tick();
        start2 = 0; p_valid2 = 1; p_data2 = 16'd65025;
        tick(); tick(); tick();
        p_valid2 = 0;
        chk("t4_ovf_sticky", 32'(res_ovf2), 1);
        res_ready2 = 1; tick(); res_ready2 = 0;

        // 5: reset mid-run, then a fresh single-beat run
        start = 1; len = 5;
        tick();
        start = 0; p_valid = 1; p_data = 100;
        tick(); tick();
        p_valid = 0;
        rst_n = 0;
        #1;
        chk("t5_rst_busy", 32'(busy), 0);
        chk("t5_rst_p_ready", 32'(p_ready), 0);
        chk("t5_rst_res_valid", 32'(res_valid), 0);
        chk("t5_rst_res_data", 32'(res_data), 0);
        tick();
        rst_n = 1;
        tick();
        q1.push_back('{data: 24'd9, ovf: 1'b0});
        start = 1; len = 1;
        tick();
        start = 0; p_valid = 1; p_data = 9;
        tick();
        p_valid = 0;
        res_ready = 1; tick(); res_ready = 0;

        // 6: clear beats start, then clear beats a result handshake
        start = 1; len = 2; clear = 1;
        tick();
        start = 0; clear = 0;
        chk("t6_start_busy", 32'(busy), 0);
        chk("t6_start_p_ready", 32'(p_ready), 0);
        start = 1; len = 1;
        tick();
        start = 0; p_valid = 1; p_data = 5;
        tick();
        p_valid = 0;
        chk("t6_done_data", 32'(res_data), 5);
        res_ready = 1; clear = 1;
        tick();
        res_ready = 0; clear = 0;
        chk("t6_clr_res_valid", 32'(res_valid), 0);
        chk("t6_clr_res_data", 32'(res_data), 0);
        chk("t6_clr_busy", 32'(busy), 0);
        tick();

        chk("q1_drained", 32'(q1.size()), 0);
        chk("q2_drained", 32'(q2.size()), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
